// File: rtl/serial_tx_arbiter_if.sv
// Signal bundle between the two byte producers, the serial pins and serial_tx_arbiter.
// The arbiter uses the slave modport; the producers and the port side use master.
interface serial_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_wren;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_wren;
  logic       req1_ready;
  logic       serial_ready_in;
  logic [7:0] serial_out;
  logic       serial_wren_out;
  logic [1:0] owner;

  modport master (
    output req0_data, req0_wren, req1_data, req1_wren, serial_ready_in,
    input  req0_ready, req1_ready, serial_out, serial_wren_out, owner
  );

  modport slave (
    input  req0_data, req0_wren, req1_data, req1_wren, serial_ready_in,
    output req0_ready, req1_ready, serial_out, serial_wren_out, owner
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Two-requester serial output arbiter: per-requester byte FIFOs feeding one serial port
// through a line-atomic round-robin grant (IDLE / OWN0 / OWN1).

module serial_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  // Ready comes from the registered count, so a full FIFO refuses a push even when popped.
  assign ready   = (count_q != FULL_COUNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && ready;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end
endmodule

module serial_tx_arbiter #(
  parameter int DEPTH        = 4,
  parameter int MAX_LINE     = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  serial_tx_arbiter_if.slave   bus
);
  localparam int BW = $clog2(MAX_LINE + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] MAX_LINE_C = BW'(MAX_LINE);
  localparam logic [BW-1:0] BYTE_ONE   = BW'(1);
  localparam logic [TW-1:0] TIMEOUT_C  = TW'(IDLE_TIMEOUT);
  localparam logic [TW-1:0] TOUT_ONE   = TW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tout_cnt_q, tout_cnt_d;
  logic [7:0]    serial_out_q, serial_out_d;
  logic          serial_wren_q, serial_wren_d;

  logic          pop0, pop1;
  logic          empty0, empty1;
  logic          ready0, ready1;
  logic [7:0]    head0, head1;
  logic          own_is1;
  logic          own_empty;
  logic          other_empty;
  logic [7:0]    own_head;
  logic          line_done;

  serial_tx_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (bus.req0_wren),
    .push_data (bus.req0_data),
    .pop       (pop0),
    .head      (head0),
    .empty     (empty0),
    .ready     (ready0)
  );

  serial_tx_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (bus.req1_wren),
    .push_data (bus.req1_data),
    .pop       (pop1),
    .head      (head1),
    .empty     (empty1),
    .ready     (ready1)
  );

  assign own_is1     = (state_q == OWN1);
  assign own_empty   = own_is1 ? empty1 : empty0;
  assign other_empty = own_is1 ? empty0 : empty1;
  assign own_head    = own_is1 ? head1 : head0;

  // last_owner_q = 1 means req1 held the port last, giving req0 priority on a tie.
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    byte_cnt_d    = byte_cnt_q;
    tout_cnt_d    = tout_cnt_q;
    serial_out_d  = serial_out_q;
    serial_wren_d = 1'b0;
    pop0          = 1'b0;
    pop1          = 1'b0;
    line_done     = 1'b0;

    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        tout_cnt_d = '0;
        if (!empty0 && (empty1 || last_owner_q)) begin
          state_d = OWN0;
        end else if (!empty1) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        if (bus.serial_ready_in && !own_empty) begin
          pop0          = !own_is1;
          pop1          = own_is1;
          serial_out_d  = own_head;
          serial_wren_d = 1'b1;
          byte_cnt_d    = byte_cnt_q + BYTE_ONE;
          tout_cnt_d    = '0;
          line_done     = (own_head == 8'h0A) || (byte_cnt_d == MAX_LINE_C);
        end else if (bus.serial_ready_in && !other_empty) begin
          // Starvation only counts while the port could have taken a byte.
          tout_cnt_d = tout_cnt_q + TOUT_ONE;
          line_done  = (tout_cnt_d == TIMEOUT_C);
        end
        if (line_done) begin
          state_d      = IDLE;
          last_owner_d = own_is1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_owner_q  <= 1'b1;
      byte_cnt_q    <= '0;
      tout_cnt_q    <= '0;
      serial_out_q  <= 8'h00;
      serial_wren_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      byte_cnt_q    <= byte_cnt_d;
      tout_cnt_q    <= tout_cnt_d;
      serial_out_q  <= serial_out_d;
      serial_wren_q <= serial_wren_d;
    end
  end

  assign bus.req0_ready      = ready0;
  assign bus.req1_ready      = ready1;
  assign bus.serial_out      = serial_out_q;
  assign bus.serial_wren_out = serial_wren_q;
  assign bus.owner           = (state_q == OWN0) ? 2'b01 :
                               (state_q == OWN1) ? 2'b10 : 2'b00;
endmodule
